lives_hud: RTL and testbench

LIVES_HUD -- requirements
Module: lives_hud

---
 rtl/lives_hud.sv | 243 ++++++++++++++++++++++++
 tb/tb_lives_hud.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lives_hud.sv
// -----------------------------------------------------------------------------
// lives_hud
//
// Life counter, invulnerability timer and on-screen HUD renderer for a simple
// game. The control side tracks the player's lives through three states
// (ALIVE, INVULN, GAME_OVER). The video side is a two-stage pixel pipeline
// that draws the word "LIVES" (from an external 32x16 glyph map) followed by
// up to seven life icons.
//
// Parameters
//   START_LIVES  life count loaded at reset and on restart (1..7)
//   INV_FRAMES   invulnerability duration in video frames   (1..255)
//
// Ports
//   Clk         in   system clock, single domain
//   Reset       in   synchronous, active-high reset
//   frame_tick  in   one-cycle pulse, once per video frame
//   hit         in   one-cycle pulse, player damaged
//   extra_life  in   one-cycle pulse, award one life
//   restart     in   one-cycle pulse, begin a new game
//   DrawX/DrawY in   current pixel column/row (10 bits each)
//   text_X      out  registered glyph-map column (6 bits)
//   text_Y      out  registered glyph-map row (4 bits)
//   text_pixel  in   glyph bit for text_X/text_Y, returned in the same cycle
//   hud_on      out  registered; pixel belongs to the HUD
//   hud_pixel   out  registered; HUD foreground bit
//   lives       out  current life count
//   game_over   out  high while in GAME_OVER
//   state_dbg   out  raw FSM state, for observation only
//
// Interface semantics
//   There is no valid/ready handshake. Every control input is a single-cycle
//   pulse sampled on the rising edge of Clk; a pulse is acted on in that cycle
//   or dropped, never remembered. The pixel path accepts one DrawX/DrawY pair
//   every cycle and presents the matching hud_on/hud_pixel exactly two cycles
//   later, with no stalls.
// -----------------------------------------------------------------------------
module lives_hud #(
    parameter int START_LIVES = 3,
    parameter int INV_FRAMES  = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       extra_life,
    input  logic       restart,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [5:0] text_X,
    output logic [3:0] text_Y,
    input  logic       text_pixel,
    output logic       hud_on,
    output logic       hud_pixel,
    output logic [2:0] lives,
    output logic       game_over,
    output logic [1:0] state_dbg
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [2:0] START_L   = 3'(START_LIVES);
    localparam logic [7:0] INV_L     = 8'(INV_FRAMES);
    localparam logic [2:0] MAX_LIVES = 3'd7;
    localparam int         N_ICONS   = 7;

    // Screen geometry of the HUD.
    localparam logic [9:0] TEXT_X0 = 10'd8;
    localparam logic [9:0] TEXT_X1 = 10'd39;
    localparam logic [9:0] TEXT_Y0 = 10'd8;
    localparam logic [9:0] TEXT_Y1 = 10'd23;
    localparam int         ICON_X0 = 48;   // left edge of icon 0
    localparam int         ICON_PITCH = 12; // column distance between icons
    localparam int         ICON_W  = 8;
    localparam logic [9:0] ICON_Y0 = 10'd12;
    localparam logic [9:0] ICON_Y1 = 10'd19;

    // -------------------------------------------------------------------------
    // Life / invulnerability FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        INVULN    = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [2:0] lives_n;
    logic [7:0] inv_cnt, inv_cnt_n;
    logic [3:0] blink_cnt, blink_cnt_n;
    logic       blink_off;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ALIVE;
            lives     <= START_L;
            inv_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            state     <= state_n;
            lives     <= lives_n;
            inv_cnt   <= inv_cnt_n;
            blink_cnt <= blink_cnt_n;
        end
    end

    // Priority is restart > hit > extra_life. A hit that is present masks
    // extra_life in every state, even where the hit itself has no effect
    // (INVULN); the masked pulse is simply lost.
    always_comb begin
        state_n     = state;
        lives_n     = lives;
        inv_cnt_n   = inv_cnt;
        blink_cnt_n = blink_cnt;

        if (restart) begin
            state_n   = ALIVE;
            lives_n   = START_L;
            inv_cnt_n = '0;
        end else begin
            case (state)
                ALIVE: begin
                    if (hit) begin
                        if (lives > 3'd1) begin
                            lives_n     = lives - 3'd1;
                            inv_cnt_n   = INV_L;
                            blink_cnt_n = '0;
                            state_n     = INVULN;
                        end else begin
                            lives_n = '0;
                            state_n = GAME_OVER;
                        end
                    end else if (extra_life && (lives != MAX_LIVES)) begin
                        lives_n = lives + 3'd1;
                    end
                end

                INVULN: begin
                    if (!hit && extra_life && (lives != MAX_LIVES)) begin
                        lives_n = lives + 3'd1;
                    end
                    if (frame_tick) begin
                        inv_cnt_n   = inv_cnt - 8'd1;
                        blink_cnt_n = blink_cnt + 4'd1;
                        // The tick that empties the timer ends invulnerability.
                        if (inv_cnt == 8'd1) begin
                            state_n = ALIVE;
                        end
                    end
                end

                GAME_OVER: begin
                    state_n = GAME_OVER;
                end

                default: begin
                    state_n = ALIVE;
                end
            endcase
        end
    end

    assign game_over = (state == GAME_OVER);
    assign state_dbg = state;

    // Icons flash with a 16-frame period while the blink counter advances.
    assign blink_off = blink_cnt[3];

    // -------------------------------------------------------------------------
    // Pixel pipeline, stage 1: region decode
    // -------------------------------------------------------------------------
    logic       in_text_c;
    logic       icon_hit_c;
    logic       icon_lit_c;
    logic [5:0] text_x_c;
    logic [3:0] text_y_c;

    always_comb begin
        in_text_c = (DrawX >= TEXT_X0) && (DrawX <= TEXT_X1) &&
                    (DrawY >= TEXT_Y0) && (DrawY <= TEXT_Y1);

        text_x_c = '0;
        text_y_c = '0;
        if (in_text_c) begin
            text_x_c = 6'(DrawX - TEXT_X0);
            text_y_c = 4'(DrawY - TEXT_Y0);
        end

        // icon_hit marks any icon slot so the HUD area stays claimed even
        // when a slot is empty; icon_lit additionally requires a life to
        // be shown in that slot.
        icon_hit_c = 1'b0;
        icon_lit_c = 1'b0;
        if ((DrawY >= ICON_Y0) && (DrawY <= ICON_Y1)) begin
            for (int i = 0; i < N_ICONS; i++) begin
                if ((DrawX >= 10'(ICON_X0 + ICON_PITCH * i)) &&
                    (DrawX <= 10'(ICON_X0 + ICON_PITCH * i + ICON_W - 1))) begin
                    icon_hit_c = 1'b1;
                    if (3'(i) < lives) begin
                        icon_lit_c = 1'b1;
                    end
                end
            end
        end
    end

    logic in_text_q;
    logic icon_hit_q;
    logic icon_lit_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            text_X     <= '0;
            text_Y     <= '0;
            in_text_q  <= 1'b0;
            icon_hit_q <= 1'b0;
            icon_lit_q <= 1'b0;
        end else begin
            text_X     <= text_x_c;
            text_Y     <= text_y_c;
            in_text_q  <= in_text_c;
            icon_hit_q <= icon_hit_c;
            icon_lit_q <= icon_lit_c;
        end
    end

    // -------------------------------------------------------------------------
    // Pixel pipeline, stage 2: compose
    // text_pixel answers the stage-1 text_X/text_Y combinationally, so it
    // lines up with the stage-1 flags here.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hud_on    <= 1'b0;
            hud_pixel <= 1'b0;
        end else begin
            hud_on    <= in_text_q | icon_hit_q;
            hud_pixel <= (in_text_q & text_pixel) | (icon_lit_q & ~blink_off);
        end
    end

endmodule

// File: tb/tb_lives_hud.sv
module tb_lives_hud;

    localparam int START_LIVES = 3;
    localparam int INV_FRAMES  = 120;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick, hit, extra_life, restart;
    logic [9:0] DrawX, DrawY;
    logic [5:0] text_X;
    logic [3:0] text_Y;
    logic       text_pixel;
    logic       hud_on, hud_pixel;
    logic [2:0] lives;
    logic       game_over;
    logic [1:0] state_dbg;

    always #5 Clk = ~Clk;

    lives_hud #(
        .START_LIVES(START_LIVES),
        .INV_FRAMES (INV_FRAMES)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .hit       (hit),
        .extra_life(extra_life),
        .restart   (restart),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .text_X    (text_X),
        .text_Y    (text_Y),
        .text_pixel(text_pixel),
        .hud_on    (hud_on),
        .hud_pixel (hud_pixel),
        .lives     (lives),
        .game_over (game_over),
        .state_dbg (state_dbg)
    );

    // Random glyph map, answered combinationally like a ROM.
    logic glyph [512];
    assign text_pixel = glyph[{text_Y, text_X[4:0]}];

    // ------------------------------------------------------------------
    // Scoreboard queues
    // ------------------------------------------------------------------
    // ctl entry: {text_X[5:0], text_Y[3:0], lives[2:0], game_over}
    logic [13:0] ctl_q[$];
    // pixel entry: {hud_on, hud_pixel}
    logic [1:0]  pix_q[$];

    typedef struct {
        string nm;
        int    kind;   // 0: lives, 1: game_over
        int    exp;
    } dir_t;
    dir_t dir_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // ------------------------------------------------------------------
    // Reference model (rule level)
    // ------------------------------------------------------------------
    int m_lives;
    int m_inv;     // frames of invulnerability left; >0 means invulnerable
    int m_blink;
    bit m_over;

    task automatic model_step(input logic rst, input logic ft, input logic h,
                              input logic el, input logic rs);
        if (rst || rs) begin
            m_lives = START_LIVES;
            m_over  = 1'b0;
            m_inv   = 0;
            if (rst) m_blink = 0;
        end else if (m_over) begin
            // everything but restart is ignored
        end else if (m_inv > 0) begin
            if (el && !h) m_lives = (m_lives < 7) ? m_lives + 1 : 7;
            if (ft) begin
                m_inv   = m_inv - 1;
                m_blink = (m_blink + 1) % 16;
            end
        end else if (h) begin
            if (m_lives > 1) begin
                m_lives = m_lives - 1;
                m_inv   = INV_FRAMES;
                m_blink = 0;
            end else begin
                m_lives = 0;
                m_over  = 1'b1;
            end
        end else if (el) begin
            m_lives = (m_lives < 7) ? m_lives + 1 : 7;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one call = one clock cycle of stimulus
    // ------------------------------------------------------------------
    task automatic cycle(input logic rst, input logic ft, input logic h,
                         input logic el, input logic rs,
                         input logic [9:0] x, input logic [9:0] y);
        bit         in_t, region, lit, gbit;
        int         dx, dy;
        logic [5:0] etx;
        logic [3:0] ety;
        logic [1:0] epx;
        @(negedge Clk);
        Reset = rst; frame_tick = ft; hit = h; extra_life = el; restart = rs;
        DrawX = x;   DrawY = y;

        in_t = (x >= 8) && (x <= 39) && (y >= 8) && (y <= 23);
        dx   = in_t ? int'(x) - 8 : 0;
        dy   = in_t ? int'(y) - 8 : 0;
        gbit = in_t ? glyph[dy * 32 + dx] : 1'b0;
        region = 1'b0;
        lit    = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (x >= 48 + 12 * i && x <= 55 + 12 * i && y >= 12 && y <= 19) begin
                region = 1'b1;
                if (i < m_lives) lit = 1'b1;   // lives as seen by stage 1
            end
        end

        model_step(rst, ft, h, el, rs);

        // Stage 2 sees the blink count as updated by this cycle.
        epx = {in_t | region, (in_t & gbit) | (lit & ((m_blink % 16) < 8))};
        etx = 6'(dx);
        ety = 4'(dy);
        if (rst) begin
            epx = 2'b00;
            etx = '0;
            ety = '0;
            // The pixel one cycle ahead is flushed out of stage 2 by this reset.
            if (pix_q.size() > 0) pix_q[pix_q.size() - 1] = 2'b00;
        end
        pix_q.push_back(epx);
        ctl_q.push_back({etx, ety, 3'(m_lives), m_over});
    endtask

    function automatic logic [9:0] rand_x();
        return ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                           : 10'($urandom_range(0, 140));
    endfunction

    function automatic logic [9:0] rand_y();
        return ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                           : 10'($urandom_range(0, 30));
    endfunction

    task automatic pulse(input logic ft, input logic h, input logic el, input logic rs);
        cycle(1'b0, ft, h, el, rs, rand_x(), rand_y());
    endtask

    task automatic ticks(input int n, input logic [9:0] x, input logic [9:0] y);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, x, y);
    endtask

    // Checked against the DUT right after the next rising edge.
    task automatic probe(input string nm, input int kind, input int exp);
        dir_t d;
        d.nm = nm; d.kind = kind; d.exp = exp;
        dir_q.push_back(d);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t state_dbg=%0d)",
                     nm, act, exp, $time, state_dbg);
        end
    endtask

    logic [13:0] mon_c;
    logic [1:0]  mon_p;
    dir_t        mon_d;

    always @(posedge Clk) begin
        #1;
        if (ctl_q.size() > 0) begin
            mon_c = ctl_q.pop_front();
            chk("text_X",    int'(text_X),    int'(mon_c[13:8]));
            chk("text_Y",    int'(text_Y),    int'(mon_c[7:4]));
            chk("lives",     int'(lives),     int'(mon_c[3:1]));
            chk("game_over", int'(game_over), int'(mon_c[0]));
        end
        // Two pixels in flight: the older one is due now.
        if (pix_q.size() >= 2) begin
            mon_p = pix_q.pop_front();
            chk("hud_on",    int'(hud_on),    int'(mon_p[1]));
            chk("hud_pixel", int'(hud_pixel), int'(mon_p[0]));
        end
        while (dir_q.size() > 0) begin
            mon_d = dir_q.pop_front();
            if (mon_d.kind == 0) chk(mon_d.nm, int'(lives), mon_d.exp);
            else                 chk(mon_d.nm, int'(game_over), mon_d.exp);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 512; i++) glyph[i] = 1'($urandom_range(0, 1));
        m_lives = START_LIVES; m_inv = 0; m_blink = 0; m_over = 1'b0;
        Reset = 1'b1; frame_tick = 1'b0; hit = 1'b0; extra_life = 1'b0;
        restart = 1'b0; DrawX = '0; DrawY = '0;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rand_x(), rand_y());
        probe("reset_lives", 0, 3);
        probe("reset_game_over", 1, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd8, 10'd8);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd39, 10'd23);

        // First hit, then the three reference pixels with lives = 2.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd8, 10'd8);
        probe("hit1_lives", 0, 2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd60, 10'd15);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd72, 10'd15);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd8,  10'd8);

        // Hit during invulnerability is ignored; icons blink with the ticks.
        ticks(10, 10'd50, 10'd15);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd50, 10'd15);
        probe("invuln_hit_ignored", 0, 2);
        ticks(110, 10'd62, 10'd13);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 10'd15);

        // Back in ALIVE: two more hits, each after a full invulnerability.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd50, 10'd15);
        probe("hit2_lives", 0, 1);
        ticks(121, 10'd48, 10'd19);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd55, 10'd12);
        probe("hit3_lives", 0, 0);
        probe("hit3_game_over", 1, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd20, 10'd10);
        probe("over_extra_ignored", 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 10'd15);

        // Coincident pulses.
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        probe("hit_beats_extra", 0, 2);
        pulse(1'b1, 1'b1, 1'b1, 1'b1);
        probe("restart_beats_all", 0, 3);
        probe("restart_game_over", 1, 0);

        // Saturation at seven lives.
        for (int i = 0; i < 7; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        probe("lives_saturate", 0, 7);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(48 + 12 * i), 10'd16);

        // Reset in the middle of invulnerability with pixels in flight.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5, 10'd20, 10'd20);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd50, 10'd15);
        probe("midrun_reset_lives", 0, 3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd50, 10'd15);
        probe("after_reset_alive", 0, 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 999) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 399) == 0),
                  rand_x(), rand_y());
        end

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        repeat (3) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
